mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle controller FSM for the single-issue MIPS-subset core.
- Decodes the held instruction and sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives datapath write enables, mux selects and the 3-bit ALUOp consumed by the ALU.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retire counter instr_cnt

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
opcode  input  6  IR[31:26], held in IR from ID through end of instruction
funct  input  6  IR[5:0]
zero  input  1  ALU result == 0, valid in EXE
ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra
ALUSrcA  output  1  0 = rs value, 1 = rt value
ALUSrcB  output  2  00 rt value, 01 extended imm, 10 zero-extended shamt
ExtOp  output  2  00 zero-ext, 01 sign-ext, 10 imm<<16
PCWrite  output  1  PC load enable
PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target, 11 rs value
IRWrite  output  1  IR load enable
MemWrite  output  1  data memory write enable
RegWrite  output  1  register file write enable
RegDst  output  2  00 rt, 01 rd, 10 $31
MemtoReg  output  2  00 ALU result, 01 memory data, 10 PC (already PC+4)
state  output  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4
retire  output  1  one-cycle pulse in the last cycle of each instruction
instr_cnt  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Supported instructions:
  - R-type (opcode 000000) by funct: addu 100001, subu 100011, and 100100, or 100101, srl 000010, sra 000011, jr 001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Any other opcode/funct combination, including sll nop, is a no-op.
- Reset:
  - state <= IF and instr_cnt <= 0.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and retire are forced 0.
  - All selects and ALUOp are forced 0.
  - Reset mid-instruction abandons it: no write, no retire.
- Outputs are combinational from state, opcode, funct and zero. Signals not listed for a state are 0.
- IF: IRWrite=1, PCWrite=1, PCSrc=00. Next state ID.
- ID:
  - j: PCWrite=1, PCSrc=10, retire. Next IF.
  - jal: as j, plus RegWrite=1, RegDst=10, MemtoReg=10. Next IF.
  - jr: PCWrite=1, PCSrc=11, retire. Next IF.
  - No-op: retire, no writes. Next IF.
  - All others: next EXE.
- EXE, ALU settings:
  - addu: ALUOp=000, ALUSrcB=00.
  - subu: ALUOp=001, ALUSrcB=00.
  - and: ALUOp=010, ALUSrcB=00.
  - or: ALUOp=011, ALUSrcB=00.
  - srl: ALUOp=100, ALUSrcA=1, ALUSrcB=10.
  - sra: ALUOp=101, ALUSrcA=1, ALUSrcB=10.
  - ori: ALUOp=011, ALUSrcB=01, ExtOp=00.
  - lui: ALUOp=000, ALUSrcB=01, ExtOp=10.
  - lw/sw: ALUOp=000, ALUSrcB=01, ExtOp=01.
  - beq: ALUOp=001, ALUSrcB=00, ExtOp=01, PCWrite=zero, PCSrc=01, retire.
  - For srl/sra, ALUSrcA=1 routes rt so the ALU computes rt >> shamt.
- EXE next state: beq -> IF; lw/sw -> MEM; other instructions -> WB.
- MEM:
  - sw: MemWrite=1, retire. Next IF.
  - lw: no writes. Next WB.
  - ALU settings are held from EXE throughout MEM.
- WB: RegWrite=1, retire. Next IF.
  - R-type: RegDst=01, MemtoReg=00.
  - ori/lui: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01.
- Latency in cycles:
  - j/jal/jr/no-op: 2.
  - beq: 3.
  - R-type/ori/lui/sw: 4.
  - lw: 5.
- instr_cnt increments in the cycle after retire is high.
- Illegal state encodings 5-7: next state IF, all enables 0.
- At most one of MemWrite/RegWrite is asserted in any cycle.

Test Plan:
1. Reset held 2 cycles, then release. Required: state=0 and all enables 0 during reset; first cycle after release IRWrite=1, PCWrite=1; instr_cnt=0.
2. Issue addu (000000/100001). Required: states IF,ID,EXE,WB. ALUOp=000 in EXE; RegWrite=1, RegDst=01 in WB; retire once; instr_cnt=1.
3. Issue sra (funct 000011). Required: EXE ALUOp=101, ALUSrcA=1, ALUSrcB=10. Issue srl (funct 000010). Required: EXE ALUOp=100.
4. lw followed by sw. Required: lw takes 5 cycles with MemtoReg=01 in WB; sw takes 4 cycles with MemWrite=1 only in MEM; instr_cnt +2.
5. beq with zero=1, then beq with zero=0. Required: PCWrite=1 and PCSrc=01 in EXE only when zero=1; each beq takes 3 cycles.
6. jal. Required: in ID PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, MemtoReg=10. Opcode 111111. Required: 2-cycle no-op with no writes and retire=1. Reset asserted in EXE of an addu. Required: no RegWrite, instr_cnt=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: sequences IF/ID/EXE/MEM/WB, drives datapath controls, counts retires.
// Latency 2-5 cycles per instruction by class; no backpressure, controls are combinational from state and IR.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic [2:0]       ALUOp,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ExtOp,
   output logic             PCWrite,
   output logic [1:0]       PCSrc,
   output logic             IRWrite,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic [1:0]       RegDst,
   output logic [1:0]       MemtoReg,
   output logic [2:0]       state,
   output logic             retire,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EXE = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [CNT_W-1:0] r_cnt;

   logic w_rtype, w_addu, w_subu, w_and, w_or, w_srl, w_sra, w_jr;
   logic w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal, w_alu_r, w_multi;
   logic [2:0] w_aluop;
   logic       w_srca;
   logic [1:0] w_srcb;
   logic [1:0] w_ext;

   assign w_rtype = (opcode == 6'b000000);
   assign w_addu  = w_rtype && (funct == 6'b100001);
   assign w_subu  = w_rtype && (funct == 6'b100011);
   assign w_and   = w_rtype && (funct == 6'b100100);
   assign w_or    = w_rtype && (funct == 6'b100101);
   assign w_srl   = w_rtype && (funct == 6'b000010);
   assign w_sra   = w_rtype && (funct == 6'b000011);
   assign w_jr    = w_rtype && (funct == 6'b001000);
   assign w_ori   = (opcode == 6'b001101);
   assign w_lui   = (opcode == 6'b001111);
   assign w_lw    = (opcode == 6'b100011);
   assign w_sw    = (opcode == 6'b101011);
   assign w_beq   = (opcode == 6'b000100);
   assign w_j     = (opcode == 6'b000010);
   assign w_jal   = (opcode == 6'b000011);
   assign w_alu_r = w_addu | w_subu | w_and | w_or | w_srl | w_sra;
   // Everything not in this set and not a jump finishes in ID as a no-op.
   assign w_multi = w_alu_r | w_ori | w_lui | w_lw | w_sw | w_beq;

   // ALU setup shared by EXE and MEM so address/data stay stable through the memory access.
   always_comb begin
      w_aluop = 3'b000;
      w_srca  = 1'b0;
      w_srcb  = 2'b00;
      w_ext   = 2'b00;
      if (w_subu) begin
         w_aluop = 3'b001;
      end else if (w_and) begin
         w_aluop = 3'b010;
      end else if (w_or) begin
         w_aluop = 3'b011;
      end else if (w_srl || w_sra) begin
         w_aluop = w_sra ? 3'b101 : 3'b100;
         w_srca  = 1'b1;
         w_srcb  = 2'b10;
      end else if (w_ori) begin
         w_aluop = 3'b011;
         w_srcb  = 2'b01;
      end else if (w_lui) begin
         w_srcb  = 2'b01;
         w_ext   = 2'b10;
      end else if (w_lw || w_sw) begin
         w_srcb  = 2'b01;
         w_ext   = 2'b01;
      end else if (w_beq) begin
         w_aluop = 3'b001;
         w_ext   = 2'b01;
      end
   end

   always_comb begin
      ALUOp    = 3'b000;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ExtOp    = 2'b00;
      PCWrite  = 1'b0;
      PCSrc    = 2'b00;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 2'b00;
      MemtoReg = 2'b00;
      retire   = 1'b0;
      w_next   = S_IF;
      if (!reset) begin
         case (r_state)
            S_IF: begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               w_next  = S_ID;
            end
            S_ID: begin
               if (w_j || w_jal) begin
                  PCWrite = 1'b1;
                  PCSrc   = 2'b10;
                  retire  = 1'b1;
                  if (w_jal) begin
                     RegWrite = 1'b1;
                     RegDst   = 2'b10;
                     MemtoReg = 2'b10;
                  end
               end else if (w_jr) begin
                  PCWrite = 1'b1;
                  PCSrc   = 2'b11;
                  retire  = 1'b1;
               end else if (w_multi) begin
                  w_next  = S_EXE;
               end else begin
                  retire  = 1'b1;
               end
            end
            S_EXE: begin
               ALUOp   = w_aluop;
               ALUSrcA = w_srca;
               ALUSrcB = w_srcb;
               ExtOp   = w_ext;
               if (w_beq) begin
                  PCWrite = zero;
                  PCSrc   = 2'b01;
                  retire  = 1'b1;
               end else if (w_lw || w_sw) begin
                  w_next  = S_MEM;
               end else begin
                  w_next  = S_WB;
               end
            end
            S_MEM: begin
               ALUOp   = w_aluop;
               ALUSrcA = w_srca;
               ALUSrcB = w_srcb;
               ExtOp   = w_ext;
               if (w_sw) begin
                  MemWrite = 1'b1;
                  retire   = 1'b1;
               end else begin
                  w_next   = S_WB;
               end
            end
            S_WB: begin
               RegWrite = 1'b1;
               retire   = 1'b1;
               RegDst   = w_rtype ? 2'b01 : 2'b00;
               MemtoReg = w_lw ? 2'b01 : 2'b00;
            end
            default: w_next = S_IF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IF;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (retire) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign state     = r_state;
   assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle expected control vectors are queued at issue and popped as the FSM steps.
// Vector layout: {state, ALUOp, ALUSrcA, ALUSrcB, ExtOp, PCWrite, PCSrc, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, retire}.
module tb_mc_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode, funct;
   logic        zero;
   logic [2:0]  ALUOp;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB, ExtOp, PCSrc, RegDst, MemtoReg;
   logic        PCWrite, IRWrite, MemWrite, RegWrite, retire;
   logic [2:0]  state;
   logic [31:0] instr_cnt;

   int n_chk = 0;
   int n_err = 0;
   int exp_cnt = 0;
   logic [21:0] q[$];
   logic [21:0] dut_vec;

   always #5 clk = ~clk;

   mc_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .state(state),
      .retire(retire), .instr_cnt(instr_cnt)
   );

   assign dut_vec = {state, ALUOp, ALUSrcA, ALUSrcB, ExtOp, PCWrite, PCSrc,
                     IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, retire};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [21:0] pk(
      input logic [2:0] st, input logic [2:0] aop, input logic sa, input logic [1:0] sb,
      input logic [1:0] ext, input logic pcw, input logic [1:0] pcs, input logic irw,
      input logic mw, input logic rw, input logic [1:0] rd, input logic [1:0] m2r, input logic ret);
      return {st, aop, sa, sb, ext, pcw, pcs, irw, mw, rw, rd, m2r, ret};
   endfunction

   task automatic push_expected(input logic [5:0] op, input logic [5:0] fn, input logic z);
      logic r, j, jal, jr, addu, subu, andi, ori_r, srl, sra, ori, lui, lw, sw, beq;
      logic [2:0] aop;
      logic       sa;
      logic [1:0] sb, ext;
      r    = (op == 6'd0);
      j    = (op == 6'b000010);
      jal  = (op == 6'b000011);
      jr   = r && (fn == 6'b001000);
      addu = r && (fn == 6'b100001);
      subu = r && (fn == 6'b100011);
      andi = r && (fn == 6'b100100);
      ori_r = r && (fn == 6'b100101);
      srl  = r && (fn == 6'b000010);
      sra  = r && (fn == 6'b000011);
      ori  = (op == 6'b001101);
      lui  = (op == 6'b001111);
      lw   = (op == 6'b100011);
      sw   = (op == 6'b101011);
      beq  = (op == 6'b000100);
      q.push_back(pk(3'd0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
      if (j || jal) begin
         q.push_back(pk(3'd1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, jal,
                        jal ? 2'd2 : 2'd0, jal ? 2'd2 : 2'd0, 1'b1));
         return;
      end
      if (jr) begin
         q.push_back(pk(3'd1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
         return;
      end
      if (!(addu || subu || andi || ori_r || srl || sra || ori || lui || lw || sw || beq)) begin
         q.push_back(pk(3'd1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
         return;
      end
      q.push_back(pk(3'd1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
      aop = 3'd0; sa = 1'b0; sb = 2'd0; ext = 2'd0;
      if (subu)  aop = 3'd1;
      if (andi)  aop = 3'd2;
      if (ori_r) aop = 3'd3;
      if (srl)   begin aop = 3'd4; sa = 1'b1; sb = 2'd2; end
      if (sra)   begin aop = 3'd5; sa = 1'b1; sb = 2'd2; end
      if (ori)   begin aop = 3'd3; sb = 2'd1; end
      if (lui)   begin sb = 2'd1; ext = 2'd2; end
      if (lw || sw) begin sb = 2'd1; ext = 2'd1; end
      if (beq)   begin aop = 3'd1; ext = 2'd1; end
      if (beq) begin
         q.push_back(pk(3'd2, aop, sa, sb, ext, z, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1));
         return;
      end
      q.push_back(pk(3'd2, aop, sa, sb, ext, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0));
      if (lw || sw) begin
         q.push_back(pk(3'd3, aop, sa, sb, ext, 1'b0, 2'd0, 1'b0, sw, 1'b0, 2'd0, 2'd0, sw));
         if (sw) return;
      end
      q.push_back(pk(3'd4, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1,
                     r ? 2'd1 : 2'd0, lw ? 2'd1 : 2'd0, 1'b1));
   endtask

   // Called during an IF cycle, before its falling edge; returns during the following IF cycle.
   task automatic issue(input string name, input logic [5:0] op, input logic [5:0] fn, input logic z);
      logic [21:0] e;
      int cyc;
      int n_exp;
      int n_ret;
      opcode = op; funct = fn; zero = z;
      push_expected(op, fn, z);
      n_exp = q.size();
      cyc = 0;
      n_ret = 0;
      while (q.size() > 0 && cyc < 8) begin
         @(negedge clk);
         e = q.pop_front();
         check($sformatf("%s_c%0d", name, cyc), {10'd0, dut_vec}, {10'd0, e});
         if (retire) n_ret++;
         cyc++;
         @(posedge clk); #1;
      end
      check({name, "_lat"}, 32'(cyc), 32'(n_exp));
      check({name, "_nret"}, 32'(n_ret), 32'd1);
      exp_cnt++;
      check({name, "_cnt"}, instr_cnt, 32'(exp_cnt));
   endtask

   initial begin
      reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_vec", {10'd0, dut_vec}, 32'd0);
      check("rst_cnt", instr_cnt, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("cnt0", instr_cnt, 32'd0);

      issue("addu", 6'b000000, 6'b100001, 1'b1);
      issue("sra",  6'b000000, 6'b000011, 1'b0);
      issue("srl",  6'b000000, 6'b000010, 1'b0);
      issue("lw",   6'b100011, 6'b000000, 1'b0);
      issue("sw",   6'b101011, 6'b000000, 1'b1);
      issue("beq1", 6'b000100, 6'b000000, 1'b1);
      issue("beq0", 6'b000100, 6'b000000, 1'b0);
      issue("jal",  6'b000011, 6'b000000, 1'b0);
      issue("ill",  6'b111111, 6'b100001, 1'b0);
      issue("subu", 6'b000000, 6'b100011, 1'b0);
      issue("and",  6'b000000, 6'b100100, 1'b0);
      issue("or",   6'b000000, 6'b100101, 1'b0);
      issue("ori",  6'b001101, 6'b000000, 1'b0);
      issue("lui",  6'b001111, 6'b000000, 1'b0);
      issue("j",    6'b000010, 6'b000000, 1'b0);
      issue("jr",   6'b000000, 6'b001000, 1'b0);
      issue("sll",  6'b000000, 6'b000000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         issue($sformatf("raddu%0d", i), 6'b000000, 6'b100001, 1'($urandom_range(1)));
      end

      // Abandon an addu in EXE: no register write, counter cleared.
      opcode = 6'b000000; funct = 6'b100001; zero = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midrst_state", 32'(state), 32'd2);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_en", {27'd0, PCWrite, IRWrite, MemWrite, RegWrite, retire}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_cnt = 0;
      check("midrst_cnt", instr_cnt, 32'd0);
      check("midrst_if", 32'(state), 32'd0);
      issue("post_rst", 6'b000000, 6'b100001, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
